hack_screen_reader: RTL

//  Master-side reader of the Hack screen region of data memory (0x4000-0x5FFF, 8K words).
//  On a start pulse it fetches every screen word in address order and serialises 512x256 pixels
//    as a valid/ready stream toward the display/video block.

---
 rtl/hack_pkg.sv | 8 +
 rtl/screen_word_buf.sv | 47 ++++
 rtl/hack_screen_reader.sv | 119 +++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: Hack screen geometry constants and the screen reader state type
package hack_pkg;
   localparam logic [14:0] SCREEN_BASE  = 15'h4000;
   localparam int          SCREEN_WORDS = 8192;
   localparam int          SCREEN_WPR   = 32;
   localparam int          SCREEN_ROWS  = 256;
   typedef enum logic [1:0] {SR_IDLE, SR_REQ, SR_WAIT, SR_SHIFT} screen_rd_state_t;
endpackage

// File: rtl/screen_word_buf.sv
// screen_word_buf: word store shifting pixels out bit 0 first; 2 words deep with HACK_SCREEN_PREFETCH_EN, else 1
module screen_word_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  logic [15:0] i_wdata,
   input  logic        i_pop,
   output logic        o_valid,
   output logic        o_bit,
   output logic [3:0]  o_bitcnt,
   output logic [1:0]  o_count
);
`ifdef HACK_SCREEN_PREFETCH_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif
   logic [15:0] r_head;
   logic [15:0] r_next;
   logic [3:0]  r_bit;
   logic [1:0]  r_cnt;
   logic [1:0]  w_wr_pos;
   logic        w_pop;
   logic        w_pop_word;
   assign w_pop      = i_pop & o_valid;
   assign w_pop_word = w_pop & (&r_bit);
   assign w_wr_pos   = r_cnt - {1'b0, w_pop_word};
   assign o_valid    = r_cnt != 2'd0;
   assign o_bit      = r_head[r_bit];
   assign o_bitcnt   = r_bit;
   assign o_count    = r_cnt;
   // head word shifts out one bit per pop; the second slot refills the head once it is exhausted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head <= '0;
         r_next <= '0;
         r_bit  <= '0;
         r_cnt  <= '0;
      end else begin
         r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop_word};
         if (w_pop) r_bit <= r_bit + 4'd1;
         if (i_push && w_wr_pos == 2'd0) r_head <= i_wdata;
         else if (w_pop_word) r_head <= r_next;
         if (DEPTH > 2'd1 && i_push && w_wr_pos == 2'd1) r_next <= i_wdata;
      end
   end
endmodule

// File: rtl/hack_screen_reader.sv
// hack_screen_reader: fetches the Hack screen words and streams them as pixels; HACK_SCREEN_PREFETCH_EN enables the prefetching fetch engine
module hack_screen_reader
   import hack_pkg::*;
#(
   parameter logic [14:0] BASE_ADDR     = SCREEN_BASE,
   parameter int          WORDS_PER_ROW = SCREEN_WPR,
   parameter int          ROWS          = SCREEN_ROWS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic [14:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [15:0] mem_rdata,
   output logic        px_valid,
   input  logic        px_ready,
   output logic        px_data,
   output logic        px_sof,
   output logic        px_eol
);
   localparam logic [12:0] LAST_WORD = 13'(WORDS_PER_ROW * ROWS - 1);
   localparam logic [12:0] LAST_COL  = 13'(WORDS_PER_ROW - 1);
   screen_rd_state_t r_state;
   screen_rd_state_t w_state_nx;
   logic [12:0] r_word;
   logic [12:0] r_wcol;
   logic        r_done;
   logic        w_push;
   logic        w_pop;
   logic        w_pop_word;
   logic        w_final;
   logic        w_last_bit;
   logic        w_buf_valid;
   logic        w_bit;
   logic [3:0]  w_bitcnt;
   logic [1:0]  w_cnt;
   assign w_last_bit = &w_bitcnt;
   assign w_pop      = w_buf_valid & px_ready;
   assign w_pop_word = w_pop & w_last_bit;
   assign w_final    = w_pop_word & (r_word == LAST_WORD);
   assign busy       = r_state != SR_IDLE;
   assign done       = r_done;
   assign px_valid   = w_buf_valid;
   assign px_data    = w_buf_valid & w_bit;
   assign px_sof     = w_buf_valid & (r_word == '0) & (w_bitcnt == 4'd0);
   assign px_eol     = w_buf_valid & (r_wcol == LAST_COL) & w_last_bit;
   screen_word_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (w_push),
      .i_wdata  (mem_rdata),
      .i_pop    (w_pop),
      .o_valid  (w_buf_valid),
      .o_bit    (w_bit),
      .o_bitcnt (w_bitcnt),
      .o_count  (w_cnt)
   );
   // frame position of the word at the head of the buffer, plus the done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_word <= '0;
         r_wcol <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_final;
         if (w_pop_word) begin
            r_word <= w_final ? '0 : r_word + 13'd1;
            r_wcol <= (w_final || r_wcol == LAST_COL) ? '0 : r_wcol + 13'd1;
         end
      end
   end
   // state register; a start in the done cycle is dropped by the next-state logic
   always_ff @(posedge clk) begin
      r_state <= !rst_n ? SR_IDLE : w_state_nx;
   end
`ifdef HACK_SCREEN_PREFETCH_EN
   localparam logic [13:0] WORDS = 14'(WORDS_PER_ROW * ROWS);
   logic [13:0] r_fidx;
   logic        r_inflight;
   assign mem_req  = busy & (r_fidx != WORDS) & ((w_cnt + {1'b0, r_inflight}) < 2'd2);
   assign mem_addr = BASE_ADDR + {2'b0, r_fidx[12:0]};
   assign w_push   = r_inflight;
   // fetch engine: keeps buffered plus in-flight words at two, independent of pixel draining
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fidx     <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= mem_req & mem_gnt;
         if (w_final) r_fidx <= '0;
         else if (mem_req & mem_gnt) r_fidx <= r_fidx + 14'd1;
      end
   end
   // busy from an accepted start until the last pixel transfers
   always_comb begin
      w_state_nx = r_state;
      if (r_state == SR_IDLE) w_state_nx = (start & ~r_done) ? SR_SHIFT : SR_IDLE;
      else w_state_nx = w_final ? SR_IDLE : r_state;
   end
`else
   assign mem_req  = (r_state == SR_REQ) & (w_cnt == 2'd0);
   assign mem_addr = BASE_ADDR + {2'b0, r_word};
   assign w_push   = r_state == SR_WAIT;
   // request, wait one cycle for data, shift the word out, then fetch the next one
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         SR_IDLE:  w_state_nx = (start & ~r_done) ? SR_REQ : SR_IDLE;
         SR_REQ:   w_state_nx = mem_gnt ? SR_WAIT : SR_REQ;
         SR_WAIT:  w_state_nx = SR_SHIFT;
         SR_SHIFT: w_state_nx = w_pop_word ? (w_final ? SR_IDLE : SR_REQ) : SR_SHIFT;
         default:  w_state_nx = SR_IDLE;
      endcase
   end
`endif
endmodule
